// File: rtl/int_writeback_controller.sv
// Integer register-file writeback controller: round-robin arbitration of writeback
// sources into a single registered write port, plus a RAW/WAW busy scoreboard for decode.
module int_writeback_controller #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [5*NUM_REQ-1:0]    req_rd_i,
    input  logic [XLEN*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic                    issue_valid_i,
    input  logic [4:0]              issue_rd_i,
    input  logic [4:0]              issue_rs1_i,
    input  logic [4:0]              issue_rs2_i,
    output logic                    issue_stall_o,
    output logic                    reg_write_o,
    output logic [4:0]              rd_o,
    output logic [XLEN-1:0]         write_data_o,
    output logic [31:0]             busy_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr_r;
    logic [31:0]        busy_r;
    logic               reg_write_r;
    logic [4:0]         rd_r;
    logic [XLEN-1:0]    write_data_r;

    logic [PW-1:0]      cand_s;
    logic               take_s;
    logic               grant_any_s;
    logic [PW-1:0]      grant_idx_s;
    logic               transfer_s;
    logic [4:0]         sel_rd_s;
    logic [XLEN-1:0]    sel_data_s;
    logic               issue_accept_s;
    logic [31:0]        set_mask_s;
    logic [31:0]        clr_mask_s;
    logic [31:0]        busy_nxt_s;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return sum[PW-1:0];
    endfunction

    // Round-robin search for the first valid requester starting at ptr_r.
    always_comb begin
        cand_s      = '0;
        take_s      = 1'b0;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s      = wrap_idx(ptr_r, i);
            take_s      = ~grant_any_s & req_valid_i[cand_s];
            grant_idx_s = take_s ? cand_s : grant_idx_s;
            grant_any_s = grant_any_s | take_s;
        end
    end

    assign transfer_s  = grant_any_s & ~rst_i;
    assign req_ready_o = transfer_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s) : '0;
    assign sel_rd_s    = req_rd_i[int'(grant_idx_s)*5 +: 5];
    assign sel_data_s  = req_data_i[int'(grant_idx_s)*XLEN +: XLEN];

    // busy_r[0] is held at 0, so an rd/rs of x0 never contributes a hazard.
    assign issue_stall_o  = ~rst_i & issue_valid_i &
                            (busy_r[issue_rs1_i] | busy_r[issue_rs2_i] | busy_r[issue_rd_i]);
    assign issue_accept_s = ~rst_i & issue_valid_i & ~issue_stall_o;

    // Scoreboard next state: clear on commit, set on issue; set applied last so it wins.
    always_comb begin
        set_mask_s = 32'h0000_0000;
        clr_mask_s = 32'h0000_0000;
        if (reg_write_r) begin
            clr_mask_s[rd_r] = 1'b1;
        end else begin
            clr_mask_s = 32'h0000_0000;
        end
        if (issue_accept_s && (issue_rd_i != 5'd0)) begin
            set_mask_s[issue_rd_i] = 1'b1;
        end else begin
            set_mask_s = 32'h0000_0000;
        end
        busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    end

    // Pointer, scoreboard and registered write-port stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r        <= '0;
            busy_r       <= 32'h0000_0000;
            reg_write_r  <= 1'b0;
            rd_r         <= 5'd0;
            write_data_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
            if (transfer_s) begin
                ptr_r        <= wrap_idx(grant_idx_s, 1);
                reg_write_r  <= (sel_rd_s != 5'd0);
                rd_r         <= sel_rd_s;
                write_data_r <= sel_data_s;
            end else begin
                reg_write_r  <= 1'b0;
            end
        end
    end

    assign reg_write_o  = reg_write_r;
    assign rd_o         = rd_r;
    assign write_data_o = write_data_r;
    assign busy_o       = busy_r;

endmodule
